// File: rtl/sad_min_tracker.sv
// sad_min_tracker: tags each candidate presented to the SAD pipeline with its
// (x, y) position and delays the tag by the pipeline latency. It tracks the
// minimum SAD and its position over one search pass and pulses `done` when
// the pass has fully retired.
// Optional feature: define SAD_MIN_TRACKER_THRESH_EN to add the sad_threshold
// input and the sticky `found` output.
module sad_min_tracker #(
   parameter int unsigned SAD_LATENCY = 4,
   parameter int unsigned COORD_W     = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic               Bus2IP_Clk,
   input  logic               Bus2IP_Reset,
   input  logic               start,
   input  logic               cand_valid,
   input  logic               cand_last,
   input  logic [COORD_W-1:0] cand_x,
   input  logic [COORD_W-1:0] cand_y,
   input  logic [31:0]        sad,
`ifdef SAD_MIN_TRACKER_THRESH_EN
   input  logic [31:0]        sad_threshold,
   output logic               found,
`endif
   output logic               busy,
   output logic               done,
   output logic [31:0]        best_sad,
   output logic [COORD_W-1:0] best_x,
   output logic [COORD_W-1:0] best_y,
   output logic [CNT_W-1:0]   cand_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic               v;
      logic               l;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } tag_t;

   state_t state, state_nxt;
   tag_t   line [SAD_LATENCY];
   tag_t   tag_in;
   tag_t   tag_ret;
   logic   pass_init;

   // Candidates are only accepted while the pass is running.
   always_comb begin
      tag_in   = '0;
      tag_in.v = cand_valid & (state == RUN);
      tag_in.l = cand_valid & cand_last & (state == RUN);
      tag_in.x = cand_x;
      tag_in.y = cand_y;
   end

   assign tag_ret   = line[SAD_LATENCY-1];
   assign pass_init = (state == IDLE) & start;

   // Tag delay line: shifts every cycle, matching the stall-free SAD pipeline.
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         for (int unsigned i = 0; i < SAD_LATENCY; i++) line[i] <= '0;
      end else begin
         line[0] <= tag_in;
         for (int unsigned i = 1; i < SAD_LATENCY; i++) line[i] <= line[i-1];
      end
   end

   // State register.
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) state <= IDLE;
      else              state <= state_nxt;
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (tag_in.l) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (tag_ret.v & tag_ret.l) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Minimum tracking and retired-candidate count; ties keep the earlier one.
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         best_sad   <= '1;
         best_x     <= '0;
         best_y     <= '0;
         cand_count <= '0;
      end else if (pass_init) begin
         best_sad   <= '1;
         best_x     <= '0;
         best_y     <= '0;
         cand_count <= '0;
      end else if (tag_ret.v) begin
         if (cand_count != '1) cand_count <= cand_count + 1'b1;
         if (sad < best_sad) begin
            best_sad <= sad;
            best_x   <= tag_ret.x;
            best_y   <= tag_ret.y;
         end
      end
   end

`ifdef SAD_MIN_TRACKER_THRESH_EN
   // Sticky flag: some retired SAD in this pass was at or below the threshold.
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset)                         found <= 1'b0;
      else if (pass_init)                       found <= 1'b0;
      else if (tag_ret.v && sad <= sad_threshold) found <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker. An external SAD pipeline is modelled
// by a queue of depth SAD_LATENCY. Expected results come from a plain min/count
// over the candidates of each pass.
module tb_sad_min_tracker;

   localparam int L    = 4;
   localparam int CW   = 4;
   localparam int SATV = 15;

   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0, cand_valid = 0, cand_last = 0;
   logic [7:0]  cand_x = 0, cand_y = 0;
   logic [31:0] sad = 0;
   logic        busy, done;
   logic [31:0] best_sad;
   logic [7:0]  best_x, best_y;
   logic [CW-1:0] cand_count;
`ifdef SAD_MIN_TRACKER_THRESH_EN
   logic [31:0] sad_threshold = 0;
   logic        found;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] thr = 0;

   bit          cv [64];
   bit          cln[64];
   logic [7:0]  cx [64];
   logic [7:0]  cy [64];
   logic [31:0] cs [64];

   sad_min_tracker #(.SAD_LATENCY(L), .COORD_W(8), .CNT_W(CW)) dut (
      .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .start(start),
      .cand_valid(cand_valid), .cand_last(cand_last),
      .cand_x(cand_x), .cand_y(cand_y), .sad(sad),
`ifdef SAD_MIN_TRACKER_THRESH_EN
      .sad_threshold(sad_threshold), .found(found),
`endif
      .busy(busy), .done(done), .best_sad(best_sad),
      .best_x(best_x), .best_y(best_y), .cand_count(cand_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cand(input int i, input bit v, input int x, input int y, input logic [31:0] s);
      cv[i] = v; cln[i] = 0; cx[i] = 8'(x); cy[i] = 8'(y); cs[i] = s;
   endtask

   // Reference: min over valid candidates (strict <, earliest wins), saturating count.
   task automatic model(input int n, output logic [31:0] es, output logic [7:0] ex,
                        output logic [7:0] ey, output int ec, output bit ef);
      es = '1; ex = 0; ey = 0; ec = 0; ef = 0;
      for (int i = 0; i < n; i++) begin
         if (cv[i]) begin
            if (ec < SATV) ec++;
            if (cs[i] < es) begin es = cs[i]; ex = cx[i]; ey = cy[i]; end
            if (cs[i] <= thr) ef = 1;
         end
      end
   endtask

   // One pass of n candidates. rst_at>0 asserts reset that many cycles after the last.
   task automatic run_pass(input string nm, input int n, input bit inj_start,
                           input bit inj_drain, input bit junk_zero, input int rst_at);
      logic [31:0] q[$];
      logic [31:0] es;
      logic [7:0]  ex, ey;
      int          ec, k;
      bit          ef;
      model(n, es, ex, ey, ec, ef);
      q.delete();
      for (int i = 0; i < L; i++) q.push_back($urandom);
`ifdef SAD_MIN_TRACKER_THRESH_EN
      sad_threshold = thr;
`endif
      start = 1; cand_valid = 0; cand_last = 0; sad = $urandom;
      tick;
      start = 0;
      check({nm, ":busy_start"}, 64'(busy), 64'd1);
      check({nm, ":init_sad"}, 64'(best_sad), 64'hFFFF_FFFF);
      check({nm, ":init_cnt"}, 64'(cand_count), 64'd0);
`ifdef SAD_MIN_TRACKER_THRESH_EN
      check({nm, ":init_found"}, 64'(found), 64'd0);
`endif
      for (int i = 0; i < n; i++) begin
         cand_valid = cv[i];
         cand_last  = (i == n - 1) ? 1'b1 : (cv[i] ? 1'b0 : cln[i]);
         cand_x = cx[i]; cand_y = cy[i];
         start  = inj_start && (i == 1);
         q.push_back(cv[i] ? cs[i] : (junk_zero ? 32'd0 : $urandom));
         sad = q.pop_front();
         tick;
      end
      start = 0;
      k = 1;
      while (1) begin
         if (rst_at > 0 && k == rst_at) begin
            rst = 1;
            #1;
            check({nm, ":rst_busy"}, 64'(busy), 64'd0);
            check({nm, ":rst_done"}, 64'(done), 64'd0);
            check({nm, ":rst_sad"}, 64'(best_sad), 64'hFFFF_FFFF);
            check({nm, ":rst_cnt"}, 64'(cand_count), 64'd0);
            cand_valid = 0; cand_last = 0;
            tick; tick;
            rst = 0;
            for (int j = 0; j < L + 3; j++) begin
               sad = 0;
               tick;
               check({nm, ":no_done_after_rst"}, 64'(done), 64'd0);
            end
            return;
         end
         if (done === 1'b1 || k >= 20) break;
         check({nm, ":busy_pass"}, 64'(busy), 64'd1);
         cand_valid = inj_drain; cand_last = inj_drain;
         cand_x = 8'($urandom); cand_y = 8'($urandom);
         q.push_back(inj_drain ? 32'd1 : $urandom);
         sad = q.pop_front();
         tick;
         k++;
      end
      check({nm, ":done_latency"}, 64'(k), 64'(L + 1));
      check({nm, ":busy_done"}, 64'(busy), 64'd0);
      check({nm, ":best_sad"}, 64'(best_sad), 64'(es));
      check({nm, ":best_x"}, 64'(best_x), 64'(ex));
      check({nm, ":best_y"}, 64'(best_y), 64'(ey));
      check({nm, ":cnt"}, 64'(cand_count), 64'(ec));
`ifdef SAD_MIN_TRACKER_THRESH_EN
      check({nm, ":found"}, 64'(found), 64'(ef));
`endif
      // Keep feeding the pipeline model after done; results must hold.
      for (int j = 0; j < L + 1; j++) begin
         cand_valid = inj_drain; cand_last = 0;
         q.push_back(inj_drain ? 32'd1 : $urandom);
         sad = q.pop_front();
         tick;
         check({nm, ":done_pulse"}, 64'(done), 64'd0);
         check({nm, ":hold_sad"}, 64'(best_sad), 64'(es));
         check({nm, ":hold_cnt"}, 64'(cand_count), 64'(ec));
      end
      cand_valid = 0; cand_last = 0;
   endtask

   initial begin
      int n;
      tick; tick;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_sad", 64'(best_sad), 64'hFFFF_FFFF);
      check("reset_xy", 64'({best_x, best_y}), 64'd0);
      check("reset_cnt", 64'(cand_count), 64'd0);
`ifdef SAD_MIN_TRACKER_THRESH_EN
      check("reset_found", 64'(found), 64'd0);
`endif
      rst = 0;
      tick;

      set_cand(0, 1, 3, 5, 32'd1000);
      run_pass("single", 1, 0, 0, 0, 0);

      set_cand(0, 1, 0, 0, 32'd500);
      set_cand(1, 1, 1, 0, 32'd200);
      set_cand(2, 1, 2, 0, 32'd300);
      set_cand(3, 1, 3, 0, 32'd200);
      run_pass("tie", 4, 0, 0, 0, 0);

      set_cand(0, 1, 7, 1, 32'd40);
      set_cand(1, 0, 8, 2, 32'd0);
      set_cand(2, 0, 9, 3, 32'd0);
      set_cand(3, 1, 10, 4, 32'd30);
      set_cand(4, 1, 11, 5, 32'd35);
      run_pass("gapped", 5, 0, 0, 1, 0);

      set_cand(0, 1, 4, 4, 32'd90);
      set_cand(1, 1, 5, 4, 32'd70);
      set_cand(2, 1, 6, 4, 32'd80);
      run_pass("ignore", 3, 1, 1, 0, 0);

      set_cand(0, 1, 1, 1, 32'd5);
      set_cand(1, 1, 2, 2, 32'd6);
      run_pass("reset_mid", 2, 0, 0, 0, 2);

      set_cand(0, 1, 12, 13, 32'd77);
      set_cand(1, 1, 14, 15, 32'd66);
      run_pass("after_rst", 2, 0, 0, 0, 0);

      thr = 250;
      set_cand(0, 1, 0, 0, 32'd300);
      set_cand(1, 1, 1, 0, 32'd250);
      run_pass("thr250", 2, 0, 0, 0, 0);
      thr = 249;
      run_pass("thr249", 2, 0, 0, 0, 0);

      // Count saturation, and minimum tracking still working past saturation.
      for (int i = 0; i < 20; i++) set_cand(i, 1, i, 20 - i, 32'(1000 - i * 10));
      run_pass("saturate", 20, 0, 0, 0, 0);

      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(1, 10);
         thr = $urandom_range(0, 25);
         for (int i = 0; i < n; i++) begin
            set_cand(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
                     $urandom_range(0, 255),
                     ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20)));
            cln[i] = 1'($urandom);
         end
         cv[n-1] = 1;
         run_pass("random", n, 1'($urandom), 1'($urandom), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Downstream consumer of the 32x32 SAD pipeline. Tags each candidate block issued to the SAD pipeline with its (x, y) position, re-aligns the tags with the pipeline's fixed latency, and tracks the minimum SAD and its position over one search pass. Reports the result to the bus-side control logic with a one-cycle `done` pulse.

## Interface
- `SAD_LATENCY`, 4: cycles from a candidate presented to the SAD pipeline to its `sad` appearing on the `sad` input; must be ≥1.
- `COORD_W`, 8: width of each candidate coordinate.
- `CNT_W`, 16: width of the retired-candidate counter.
- `Bus2IP_Clk`  in  1  sole clock, rising edge.
- `Bus2IP_Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a search pass; honoured only in IDLE.
- `cand_valid`  in  1  a candidate is presented to the SAD pipeline this cycle.
- `cand_last`  in  1  final candidate of the pass; qualified by `cand_valid`.
- `cand_x`, `cand_y`  in  COORD_W each  position of the presented candidate.
- `sad`  in  32  SAD pipeline output.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse; best_* are final during this cycle.
- `best_sad`  out  32  minimum SAD so far.
- `best_x`, `best_y`  out  COORD_W each  position of `best_sad`.
- `cand_count`  out  CNT_W  number of retired valid candidates in this pass.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE →RUN on `start`. On that edge: `best_sad`=32'hFFFF_FFFF, `best_x`=`best_y`=0, `cand_count`=0.
  - RUN→DRAIN on `cand_valid & cand_last`.
  - DRAIN→DONE on the edge where the tag marked last retires.
  - DONE→IDLE unconditionally after one cycle.
- Tag delay line: SAD_LATENCY stages of {valid, last, x, y}. It shifts every cycle with no stall, because the SAD pipeline has none.
- Stage input: `cand_valid` is gated to 0 outside RUN. Candidates in IDLE, DRAIN or DONE are ignored.
- A tag retires when it reaches the final stage. The `sad` value on the same cycle belongs to that tag.
- Retired valid tag:
  - `cand_count` increments, saturating at all-ones.
  - If `sad < best_sad` (unsigned, strict), `best_sad`, `best_x` and `best_y` load the new value. Ties keep the earliest candidate.
- `start` outside IDLE is ignored.
- `cand_last` without `cand_valid` is ignored.
- If no valid candidate retires, `done` still pulses, with `best_sad`=all-ones and `cand_count`=0.
- best_* and `cand_count` hold their values after DONE until the next `start`.

## Timing
- Reset values: state=IDLE, delay line all-zero, `busy`=0, `done`=0, `best_sad`=32'hFFFF_FFFF, `best_x`=`best_y`=0, `cand_count`=0.
- Candidate at cycle t: its SAD is compared in cycle t+SAD_LATENCY, and the updated best_* are visible at t+SAD_LATENCY+1.
- Last candidate at cycle t: DRAIN covers cycles t+1..t+SAD_LATENCY, and `done`=1 at cycle t+SAD_LATENCY+1.
- `busy` rises the cycle after `start` and falls in the DONE cycle.
- Throughput: one candidate per cycle, back-to-back.
- Reset asserted mid-pass: every register returns to its reset value immediately. Stale `sad` values already inside the pipeline are discarded, because all tags are cleared.

## Configuration
- `SAD_MIN_TRACKER_THRESH_EN` defined adds two ports:
  - `sad_threshold`  in  32.
  - `found`  out  1, registered, reset 0.
- `found` is cleared on `start`. It is set when a retired valid SAD is ≤ `sad_threshold`, and stays set until the next `start` or reset.
- Undefined: neither port exists, and behaviour is otherwise identical.

## Test plan
- Single candidate (x=3, y=5) at cycle 10 with sad=1000 presented at cycle 14 -> `done` at cycle 15; best_sad=1000, best=(3,5), cand_count=1.
- Back-to-back SADs 500, 200, 300, 200 at (0,0), (1,0), (2,0), (3,0), with last on the 4th -> best_sad=200, best=(1,0), cand_count=4; the tie keeps the earlier candidate.
- Gapped `cand_valid` (1,0,0,1,1 with last on the 5th); the 0-cycle `sad` inputs are driven to 0 -> those zeros are never selected and cand_count=3.
- `start` pulsed during RUN, and `cand_valid` during DRAIN with sad=1 -> both ignored; result matches a run without them.
- Reset asserted two cycles after `cand_last` -> `busy`=0, no `done`, best_sad=FFFF_FFFF; a new pass afterwards gives correct results.
- With SAD_MIN_TRACKER_THRESH_EN and threshold=250, SADs 300 then 250 -> `found`=1 after the second retires. With threshold=249, `found` stays 0.
